eth_csr_cmd_bridge: RTL

ETH_CSR_CMD_BRIDGE -- requirements
Module: eth_csr_cmd_bridge

---
 rtl/eth_csr_cmd_bridge_if.sv | 33 +++
 rtl/eth_csr_cmd_bridge.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/eth_csr_cmd_bridge_if.sv
// Avalon-MM bus between the Ethernet CSR command bridge (master) and the CSR fabric (slave).
// Strobe semantics: the master holds read/write with stable address/data until it samples waitrequest=0 on a rising edge.
interface eth_csr_cmd_bridge_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] avmm_address;
    logic              avmm_write;
    logic              avmm_read;
    logic [31:0]       avmm_writedata;
    logic              avmm_waitrequest;
    logic [31:0]       avmm_readdata;
    logic              avmm_readdatavalid;

    modport master (
        output avmm_address,
        output avmm_write,
        output avmm_read,
        output avmm_writedata,
        input  avmm_waitrequest,
        input  avmm_readdata,
        input  avmm_readdatavalid
    );

    modport slave (
        input  avmm_address,
        input  avmm_write,
        input  avmm_read,
        input  avmm_writedata,
        output avmm_waitrequest,
        output avmm_readdata,
        output avmm_readdatavalid
    );
endinterface

// File: rtl/eth_csr_cmd_bridge.sv
// Turns edge-triggered command words from the Ethernet CSR block into single Avalon-MM
// read/write transactions, with a per-transaction timeout that aborts a stuck slave.
module eth_csr_cmd_bridge #(
    parameter int          ADDR_W         = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 eth_ctrl_addr,
    input  logic [31:0]                 eth_wr_data,
    output logic [31:0]                 eth_rd_data,
    output logic                        busy,
    output logic                        err_timeout,
    output logic [2:0]                  dbg_state_o,
    eth_csr_cmd_bridge_if.master        avmm
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              cmd_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cmd_now;
    logic              accept;
    logic              timeout_hit;

    // cmd_q resets high so a command word held through reset does not look like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_now;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cmd_now     = eth_ctrl_addr[16] | eth_ctrl_addr[17];
        accept      = cmd_now & ~cmd_q & (state_q == ST_IDLE);
        timeout_hit = (cnt_q == CNT_LAST);

        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = ADDR_W'(eth_ctrl_addr[15:0]);
                    wdata_d = eth_wr_data;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = eth_ctrl_addr[16] ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (!avmm.avmm_waitrequest) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end

            // A zero-latency slave returns readdatavalid on the same edge it drops waitrequest.
            ST_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (!avmm.avmm_waitrequest) begin
                    if (avmm.avmm_readdatavalid) begin
                        rdata_d = avmm.avmm_readdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = TIMEOUT_DATA;
                    state_d = ST_DONE;
                end
            end

            ST_RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (avmm.avmm_readdatavalid) begin
                    rdata_d = avmm.avmm_readdata;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = TIMEOUT_DATA;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!cmd_now) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign avmm.avmm_address   = addr_q;
    assign avmm.avmm_writedata = wdata_q;
    assign avmm.avmm_write     = (state_q == ST_WR);
    assign avmm.avmm_read      = (state_q == ST_RD);

    assign eth_rd_data = rdata_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule
